// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_wb_scheduler_pkg: register-bank geometry and write-back requester indices
package regfile_wb_scheduler_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: issue and write-back handshake bundle
//   master: decode/execute side (drives issue_* and wb_valid/addr/data, sees readies)
//   slave : scheduler side (returns issue_ready and wb_ready grants)
interface regfile_wb_scheduler_if;
    import regfile_wb_scheduler_pkg::*;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_ready;
    logic [1:0]        wb_valid;
    logic [ADDR_W-1:0] wb_addr0;
    logic [ADDR_W-1:0] wb_addr1;
    logic [DATA_W-1:0] wb_data0;
    logic [DATA_W-1:0] wb_data1;
    logic [1:0]        wb_ready;
    modport master (
        output issue_valid, issue_addr, wb_valid, wb_addr0, wb_addr1, wb_data0, wb_data1,
        input  issue_ready, wb_ready
    );
    modport slave (
        input  issue_valid, issue_addr, wb_valid, wb_addr0, wb_addr1, wb_data0, wb_data1,
        output issue_ready, wb_ready
    );
endinterface

// File: rtl/regfile_wb_scheduler_arb.sv
// rr_arbiter2: two-way round-robin arbiter
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : requests (bit 0 = ALU, bit 1 = load)
//   gnt[1:0]   : combinational one-hot grant
module rr_arbiter2
    import regfile_wb_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    // last_grant names the requester served most recently; it resets to load so the ALU wins first
    logic last_grant;
    assign gnt[WB_ALU]  = req[WB_ALU]  & (~req[WB_LOAD] | last_grant);
    assign gnt[WB_LOAD] = req[WB_LOAD] & (~req[WB_ALU]  | ~last_grant);
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (|gnt)
            last_grant <= gnt[WB_LOAD];
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register-bank write port and tracks outstanding producers
//   clk, reset             : clock and synchronous active-high reset
//   wb                     : issue/write-back handshake (slave side)
//   addrRead_A/B, stall_A/B: decode source addresses and their not-yet-readable flags
//   write_en/addrWrite/dataIn : registered bank write controls
//   wb_error               : sticky flag for a write-back to a register that was not busy
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    regfile_wb_scheduler_if.slave wb,
    input  logic [ADDR_W-1:0] addrRead_A,
    input  logic [ADDR_W-1:0] addrRead_B,
    output logic              stall_A,
    output logic              stall_B,
    output logic              write_en,
    output logic [ADDR_W-1:0] addrWrite,
    output logic [DATA_W-1:0] dataIn,
    output logic              wb_error
);
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [1:0]          gnt;
    logic                any_gnt;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (reset ? 2'b00 : wb.wb_valid),
        .gnt   (gnt)
    );

    assign wb.wb_ready    = gnt;
    assign any_gnt        = |gnt;
    assign sel_addr       = gnt[WB_LOAD] ? wb.wb_addr1 : wb.wb_addr0;
    assign sel_data       = gnt[WB_LOAD] ? wb.wb_data1 : wb.wb_data0;
    assign wb.issue_ready = ~reset & wb.issue_valid & ~busy[wb.issue_addr];

    // Register 0 never gets a busy bit; an issue and a grant to the same address cannot coincide
    assign set_mask = (wb.issue_ready && wb.issue_addr != REG_ZERO) ? NUM_REGS'(1) << wb.issue_addr : '0;
    assign clr_mask = (any_gnt && sel_addr != REG_ZERO) ? NUM_REGS'(1) << sel_addr : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= '0;
            write_en  <= 1'b0;
            addrWrite <= '0;
            dataIn    <= '0;
            wb_error  <= 1'b0;
        end else begin
            busy     <= (busy | set_mask) & ~clr_mask;
            write_en <= any_gnt && sel_addr != REG_ZERO;
            if (any_gnt) begin
                addrWrite <= sel_addr;
                dataIn    <= sel_data;
            end
            if (any_gnt && sel_addr != REG_ZERO && !busy[sel_addr])
                wb_error <= 1'b1;
        end
    end

    // The write_en term covers the cycle the write is registered but not yet in the bank
    assign stall_A = addrRead_A != REG_ZERO && (busy[addrRead_A] || (write_en && addrWrite == addrRead_A));
    assign stall_B = addrRead_B != REG_ZERO && (busy[addrRead_B] || (write_en && addrWrite == addrRead_B));
endmodule
